// File: rtl/dma_channel_arbiter.sv
// rtl/dma_channel_arbiter.sv - DMA request arbiter with hold handshake, fixed/rotating priority
// Optional software request feature: define DMA_SWREQ_EN to add swreq_i and its sticky register.
module dma_channel_arbiter #(
   parameter int CHANNELS = 4,
   parameter int CHW      = $clog2(CHANNELS)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic [CHANNELS-1:0] dreq_i,
   input  logic [CHANNELS-1:0] mask_i,
   input  logic                rot_pri_i,
   input  logic                hlda_i,
   input  logic                eop_n_i,
`ifdef DMA_SWREQ_EN
   input  logic [CHANNELS-1:0] swreq_i,
`endif
   output logic                hrq_o,
   output logic [CHANNELS-1:0] dack_o,
   output logic [CHW-1:0]      active_ch_o
);

   typedef enum logic [1:0] {IDLE, HREQ, GRANT, RELEASE} state_t;

   state_t              state_q, state_d;
   logic                hrq_q, hrq_d;
   logic [CHANNELS-1:0] dack_q, dack_d;
   logic [CHW-1:0]      active_ch_q, active_ch_d;
   logic [CHW-1:0]      ptr_q;
   logic [CHW-1:0]      win_idx;
   logic [CHANNELS-1:0] elig;
   int                  idx;

`ifdef DMA_SWREQ_EN
   logic [CHANNELS-1:0] sticky_q, sticky_d;

   // Software pulses accumulate until the channel they requested is released
   always_comb begin
      sticky_d = sticky_q;
      if (state_q == RELEASE) begin
         sticky_d[active_ch_q] = 1'b0;
      end
      sticky_d = sticky_d | swreq_i;
   end

   // Sticky software request register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sticky_q <= '0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign elig = (dreq_i | sticky_q) & ~mask_i;
`else
   assign elig = dreq_i & ~mask_i;
`endif

   // Winner search: descending loop so the closest candidate to the start point is kept last
   always_comb begin
      win_idx = '0;
      idx     = 0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (rot_pri_i) begin
            idx = int'(ptr_q) + 1 + i;
            if (idx >= CHANNELS) begin
               idx = idx - CHANNELS;
            end
         end else begin
            idx = i;
         end
         if (elig[idx]) begin
            win_idx = CHW'(idx);
         end
      end
   end

   // State register, registered outputs and last-serviced pointer
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         hrq_q       <= 1'b0;
         dack_q      <= '0;
         active_ch_q <= '0;
         ptr_q       <= CHW'(CHANNELS - 1);
      end else begin
         state_q     <= state_d;
         hrq_q       <= hrq_d;
         dack_q      <= dack_d;
         active_ch_q <= active_ch_d;
         if (state_q == RELEASE) begin
            ptr_q <= active_ch_q;
         end
      end
   end

   // Next-state logic; a grant is never re-arbitrated, only released
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (elig != '0) state_d = HREQ;
         HREQ: begin
            if (elig == '0)  state_d = IDLE;
            else if (hlda_i) state_d = GRANT;
         end
         GRANT: begin
            if (!elig[active_ch_q] || !eop_n_i || !hlda_i) state_d = RELEASE;
         end
         RELEASE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output next values derived from the upcoming state so outputs stay registered
   always_comb begin
      hrq_d       = (state_d == HREQ) || (state_d == GRANT);
      dack_d      = '0;
      active_ch_d = active_ch_q;
      if (state_q == HREQ && state_d == GRANT) begin
         dack_d[win_idx] = 1'b1;
         active_ch_d     = win_idx;
      end else if (state_d == GRANT) begin
         dack_d = dack_q;
      end
   end

   assign hrq_o       = hrq_q;
   assign dack_o      = dack_q;
   assign active_ch_o = active_ch_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb/tb_dma_channel_arbiter.sv - scoreboard bench for dma_channel_arbiter (CHANNELS=4)
module tb_dma_channel_arbiter;

   typedef struct {
      logic       hrq;
      logic [3:0] dack;
      logic [1:0] ch;
      logic       chk_ch;
      string      name;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [3:0] dreq_i, mask_i;
   logic       rot_pri_i, hlda_i, eop_n_i;
`ifdef DMA_SWREQ_EN
   logic [3:0] swreq_i;
`endif
   logic       hrq_o;
   logic [3:0] dack_o;
   logic [1:0] active_ch_o;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk_i = ~clk_i;

   dma_channel_arbiter #(.CHANNELS(4)) dut (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .dreq_i      (dreq_i),
      .mask_i      (mask_i),
      .rot_pri_i   (rot_pri_i),
      .hlda_i      (hlda_i),
      .eop_n_i     (eop_n_i),
`ifdef DMA_SWREQ_EN
      .swreq_i     (swreq_i),
`endif
      .hrq_o       (hrq_o),
      .dack_o      (dack_o),
      .active_ch_o (active_ch_o)
   );

   // Monitor: every pushed expectation is checked mid-cycle after its edge
   always @(negedge clk_i) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_chk++;
         if (hrq_o !== e.hrq || dack_o !== e.dack || (e.chk_ch && active_ch_o !== e.ch)) begin
            n_fail++;
            $display("FAIL %s: got hrq=%b dack=%b ch=%0d, want hrq=%b dack=%b ch=%0d%s",
                     e.name, hrq_o, dack_o, active_ch_o, e.hrq, e.dack, e.ch,
                     e.chk_ch ? "" : " (ch unchecked)");
         end
      end
   end

   task automatic expect_edge(input logic hrq, input logic [3:0] dack, input int ch,
                              input logic chk_ch, input string name);
      exp_t e;
      @(posedge clk_i);
      e.hrq = hrq; e.dack = dack; e.ch = 2'(ch); e.chk_ch = chk_ch; e.name = name;
      sb.push_back(e);
      #1;
   endtask

   task automatic idle_edge(input string name);
      expect_edge(1'b0, 4'b0000, 0, 1'b0, name);
   endtask

   task automatic do_reset(input string name);
      reset_i = 1'b1;
      expect_edge(1'b0, 4'b0000, 0, 1'b1, name);
      reset_i = 1'b0;
   endtask

   initial begin
      reset_i = 1'b1; dreq_i = '0; mask_i = '0; rot_pri_i = 1'b0;
      hlda_i = 1'b1; eop_n_i = 1'b1;
`ifdef DMA_SWREQ_EN
      swreq_i = '0;
`endif
      #1;
      do_reset("reset");

      // Fixed priority: lowest index wins, no preemption while granted
      dreq_i = 4'b1010;
      expect_edge(1'b1, 4'b0000, 0, 1'b0, "fix_hreq");
      expect_edge(1'b1, 4'b0010, 1, 1'b1, "fix_grant1");
      expect_edge(1'b1, 4'b0010, 1, 1'b1, "fix_hold1");
      dreq_i = 4'b1000;
      idle_edge("fix_rel1");
      idle_edge("fix_idle1");
      expect_edge(1'b1, 4'b0000, 0, 1'b0, "fix_hreq3");
      expect_edge(1'b1, 4'b1000, 3, 1'b1, "fix_grant3");
      dreq_i = 4'b1001;
      expect_edge(1'b1, 4'b1000, 3, 1'b1, "fix_nopreempt");
      dreq_i = 4'b0001;
      idle_edge("fix_rel3");
      idle_edge("fix_idle3");
      expect_edge(1'b1, 4'b0000, 0, 1'b0, "fix_hreq0");
      expect_edge(1'b1, 4'b0001, 0, 1'b1, "fix_grant0");
      dreq_i = 4'b0000;
      idle_edge("fix_rel0");
      idle_edge("fix_idle0");

      // Rotating priority with all channels requesting, EOP ends each grant
      do_reset("reset_rot");
      rot_pri_i = 1'b1; dreq_i = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         expect_edge(1'b1, 4'b0000, 0, 1'b0, $sformatf("rot_hreq%0d", k));
         expect_edge(1'b1, 4'(1 << (k % 4)), k % 4, 1'b1, $sformatf("rot_grant%0d", k));
         eop_n_i = 1'b0;
         idle_edge($sformatf("rot_rel%0d", k));
         eop_n_i = 1'b1;
         if (k == 4) dreq_i = 4'b0000;
         idle_edge($sformatf("rot_idle%0d", k));
      end
      rot_pri_i = 1'b0;

      // Request withdrawn while waiting for HLDA
      hlda_i = 1'b0; dreq_i = 4'b0100;
      expect_edge(1'b1, 4'b0000, 0, 1'b0, "wd_hreq");
      expect_edge(1'b1, 4'b0000, 0, 1'b0, "wd_wait");
      dreq_i = 4'b0000;
      idle_edge("wd_drop");
      idle_edge("wd_idle");

      // EOP pulse on ch2, then simultaneous EOP and request drop
      hlda_i = 1'b1; dreq_i = 4'b0100;
      expect_edge(1'b1, 4'b0000, 0, 1'b0, "eop_hreq");
      expect_edge(1'b1, 4'b0100, 2, 1'b1, "eop_grant");
      eop_n_i = 1'b0;
      idle_edge("eop_rel");
      eop_n_i = 1'b1;
      idle_edge("eop_idle");
      expect_edge(1'b1, 4'b0000, 0, 1'b0, "eop_rehreq");
      expect_edge(1'b1, 4'b0100, 2, 1'b1, "eop_regrant");
      eop_n_i = 1'b0; dreq_i = 4'b0000;
      idle_edge("both_rel");
      eop_n_i = 1'b1;
      idle_edge("both_idle");
      idle_edge("both_stay");

      // HLDA loss ends a grant
      dreq_i = 4'b0010;
      expect_edge(1'b1, 4'b0000, 0, 1'b0, "hl_hreq");
      expect_edge(1'b1, 4'b0010, 1, 1'b1, "hl_grant");
      hlda_i = 1'b0;
      idle_edge("hl_rel");
      dreq_i = 4'b0000; hlda_i = 1'b1;
      idle_edge("hl_idle");

      // Mask blocks a request; reset mid-grant
      mask_i = 4'b0001; dreq_i = 4'b0001;
      idle_edge("mask_a");
      idle_edge("mask_b");
      mask_i = 4'b0000;
      expect_edge(1'b1, 4'b0000, 0, 1'b0, "mask_hreq");
      expect_edge(1'b1, 4'b0001, 0, 1'b1, "mask_grant");
      do_reset("rst_mid");
      dreq_i = 4'b0000;
      idle_edge("rst_after");

`ifdef DMA_SWREQ_EN
      swreq_i = 4'b0100;
      idle_edge("sw_latch");
      swreq_i = 4'b0000;
      expect_edge(1'b1, 4'b0000, 0, 1'b0, "sw_hreq");
      expect_edge(1'b1, 4'b0100, 2, 1'b1, "sw_grant");
      eop_n_i = 1'b0;
      idle_edge("sw_rel");
      eop_n_i = 1'b1;
      idle_edge("sw_idle");
      idle_edge("sw_noregrant");
`endif

      for (int w = 0; w < 10 && sb.size() > 0; w++) @(posedge clk_i);
      @(posedge clk_i);
      if (sb.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
